// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and helpers for the APB register file
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    typedef struct packed {
        logic ready;
        logic err;
    } apb_resp_t;

    // Number of byte-offset address bits below the word index.
    function automatic int ADDR_LSB(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_regfile_cell.sv
// rtl/apb_regfile_cell.sv - one byte-strobed control register with reset value
module apb_regfile_cell
    import apb_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   q_o
);

    logic [DATA_WIDTH-1:0] q_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= RESET_VAL;
        end else if (en_i) begin
            for (int k = 0; k < DATA_WIDTH / 8; k++) begin
                if (strb_i[k]) begin
                    q_q[8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - APB completer with strobed control registers and a status word
module apb_regfile
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [2:0]                     pprot,
    input  logic                           pnse,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    input  logic [DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int LSB = ADDR_LSB(DATA_WIDTH);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int IW  = $clog2(NUM_REGS + 1);
    localparam int CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    apb_state_t            state_q;
    logic [IW-1:0]         idx_q;
    logic                  wr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [NB-1:0]         strb_q;
    logic [CW-1:0]         cnt_q;
    logic [NUM_REGS-1:0]   reg_wr_q;
    logic [NUM_REGS-1:0]   reg_wr_d;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  setup;
    logic                  misaligned;
    logic                  status_hit;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  commit;
    apb_resp_t             resp;
    logic                  unused_in;

    assign unused_in  = ^{pprot, pnse};
    assign word_idx   = paddr >> LSB;
    assign setup      = psel & ~penable;
    assign misaligned = (paddr & ADDR_WIDTH'(NB - 1)) != '0;
    assign status_hit = word_idx == ADDR_WIDTH'(NUM_REGS);
    assign dec_err    = misaligned | (word_idx > ADDR_WIDTH'(NUM_REGS)) | (pwrite & status_hit);

    // Read word is frozen at the setup edge so late status changes are not seen.
    always_comb begin
        rd_word = '0;
        if (!dec_err) begin
            if (status_hit) begin
                rd_word = status_in;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (word_idx == ADDR_WIDTH'(i)) begin
                        rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        resp.ready = (state_q == ACCESS) & (cnt_q == '0) & psel & penable;
        resp.err   = err_q;
    end

    assign commit = resp.ready & wr_q & ~err_q;

    always_comb begin
        reg_wr_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_wr_d[i] = commit & (idx_q == IW'(i));
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            strb_q   <= '0;
            cnt_q    <= '0;
            reg_wr_q <= '0;
        end else begin
            reg_wr_q <= reg_wr_d;
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        idx_q   <= word_idx[IW-1:0];
                        wr_q    <= pwrite;
                        err_q   <= dec_err;
                        wdata_q <= pwdata;
                        strb_q  <= pstrb;
                        rdata_q <= pwrite ? '0 : rd_word;
                        cnt_q   <= CW'(WAIT_CYCLES);
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A dropped psel is an abort: leave without committing.
                    if (!psel || resp.ready) begin
                        state_q <= IDLE;
                    end else if (penable && cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        apb_regfile_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .RESET_VAL  (RESET_VAL)
        ) u_cell (
            .clk_i   (pclk),
            .rst_i   (preset),
            .en_i    (reg_wr_d[g]),
            .strb_i  (strb_q),
            .wdata_i (wdata_q),
            .q_o     (reg_q[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign pready  = resp.ready;
    assign pslverr = resp.ready & resp.err;
    assign prdata  = resp.ready ? rdata_q : '0;
    assign reg_wr  = reg_wr_q;

endmodule

// File: tb/tb_apb_regfile.sv
// tb/tb_apb_regfile.sv - scoreboard bench for apb_regfile with zero and three wait states
module tb_apb_regfile;

    localparam logic [31:0] RV1 = 32'h1234_5678;

    typedef struct {
        logic [31:0]  rdata;
        logic         err;
        logic         wr_ok;
        int           idx;
        logic [255:0] img;
    } exp_t;

    logic              pclk = 1'b0;
    logic              preset;
    logic [31:0]       paddr;
    logic [2:0]        pprot;
    logic              pnse;
    logic [1:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [31:0]       status_in;
    logic [1:0]        pready_w;
    logic [1:0]        pslverr_w;
    logic [1:0][31:0]  prdata_w;
    logic [1:0][255:0] regq_w;
    logic [1:0][7:0]   regwr_w;

    exp_t         sbq0[$];
    exp_t         sbq1[$];
    logic [31:0]  model[2][8];
    logic [31:0]  rv[2]     = '{32'h0, RV1};
    int           wait_c[2] = '{0, 3};
    logic [7:0]   exp_wr[2];
    logic [255:0] img_q[2];
    logic         img_chk[2];
    int           tests = 0;
    int           fails = 0;

    always #5 pclk = ~pclk;

    apb_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(0), .RESET_VAL(32'h0)
    ) dut0 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .pprot(pprot), .pnse(pnse),
        .psel(psel[0]), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_w[0]), .prdata(prdata_w[0]), .pslverr(pslverr_w[0]),
        .status_in(status_in), .reg_q(regq_w[0]), .reg_wr(regwr_w[0])
    );

    apb_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(3), .RESET_VAL(RV1)
    ) dut1 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .pprot(pprot), .pnse(pnse),
        .psel(psel[1]), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_w[1]), .prdata(prdata_w[1]), .pslverr(pslverr_w[1]),
        .status_in(status_in), .reg_q(regq_w[1]), .reg_wr(regwr_w[1])
    );

    task automatic chk(input string name, input int d, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    function automatic logic [255:0] img_of(input int d);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = model[d][i];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) model[d][i] = rv[d];
    endtask

    task automatic idle();
        @(posedge pclk); #1;
        psel = 2'b00;
        penable = 1'b0;
    endtask

    // One complete transfer; expectations come from the architectural rules.
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic scramble);
        exp_t e;
        int   idx;
        int   lat;
        idx     = int'(addr >> 2);
        e.err   = (addr[1:0] != 2'b00) || (idx > 8) || (wr && idx == 8);
        e.wr_ok = wr && !e.err;
        e.idx   = idx;
        e.rdata = 32'h0;
        @(posedge pclk); #1;
        psel    = (d == 0) ? 2'b01 : 2'b10;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        if (!wr && !e.err) e.rdata = (idx == 8) ? status_in : model[d][idx];
        if (e.wr_ok)
            for (int k = 0; k < 4; k++)
                if (strb[k]) model[d][idx][8*k +: 8] = wdata[8*k +: 8];
        e.img = img_of(d);
        if (d == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
        @(posedge pclk); #1;
        penable = 1'b1;
        if (scramble) status_in = ~status_in;
        lat = 1;
        @(negedge pclk);
        while (!pready_w[d] && lat < 16) begin
            @(negedge pclk);
            lat++;
        end
        chk("latency", d, 256'(lat), 256'(wait_c[d] + 1));
    endtask

    always @(negedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            if (preset) begin
                exp_wr[d]  = 8'h00;
                img_chk[d] = 1'b0;
            end else begin
                chk("reg_wr", d, 256'(regwr_w[d]), 256'(exp_wr[d]));
                if (img_chk[d]) chk("reg_q", d, regq_w[d], img_q[d]);
                exp_wr[d]  = 8'h00;
                img_chk[d] = 1'b0;
                if (pready_w[d]) begin
                    if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pready dut%0d: got 1 expected 0", d);
                    end else begin
                        exp_t e;
                        if (d == 0) e = sbq0.pop_front();
                        else        e = sbq1.pop_front();
                        chk("prdata", d, 256'(prdata_w[d]), 256'(e.rdata));
                        chk("pslverr", d, 256'(pslverr_w[d]), 256'(e.err));
                        exp_wr[d]  = e.wr_ok ? (8'd1 << e.idx) : 8'd0;
                        img_q[d]   = e.img;
                        img_chk[d] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b1; paddr = '0; pprot = '0; pnse = 1'b0; psel = 2'b00; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pstrb = '0; status_in = '0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_pready", d, 256'(pready_w[d]), 256'(0));
            chk("rst_pslverr", d, 256'(pslverr_w[d]), 256'(0));
            chk("rst_prdata", d, 256'(prdata_w[d]), 256'(0));
            chk("rst_reg_q", d, regq_w[d], {8{rv[d]}});
        end

        xfer(0, 32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0);
        xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("reg1_value", 0, 256'(regq_w[0][63:32]), 256'(32'hDEADBEEF));

        xfer(0, 32'h00, 1'b1, 32'h11223344, 4'hF, 1'b0);
        xfer(0, 32'h00, 1'b1, 32'hAABBCCDD, 4'h5, 1'b0);
        xfer(0, 32'h00, 1'b0, 32'h0, 4'h0, 1'b0);
        idle();
        @(negedge pclk);
        chk("strobe_merge", 0, 256'(regq_w[0][31:0]), 256'(32'h11BB33DD));

        xfer(0, 32'h24, 1'b0, 32'h0, 4'h0, 1'b0);
        xfer(0, 32'h20, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b0);
        xfer(0, 32'h02, 1'b0, 32'h0, 4'h0, 1'b0);
        xfer(0, 32'h08, 1'b1, 32'h0000BEEF, 4'h0, 1'b0);

        status_in = 32'h5A;
        xfer(1, 32'h20, 1'b0, 32'h0, 4'h0, 1'b1);
        idle();

        xfer(0, 32'h00, 1'b1, 32'hCAFE0001, 4'hF, 1'b0);
        xfer(0, 32'h00, 1'b0, 32'h0, 4'h0, 1'b0);
        idle();

        // Reset in the middle of a waited write must leave reg 2 untouched.
        @(posedge pclk); #1;
        psel = 2'b10; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1;
        pwdata = 32'hFEEDF00D; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        #1;
        chk("abort_pready", 1, 256'(pready_w[1]), 256'(0));
        chk("abort_pslverr", 1, 256'(pslverr_w[1]), 256'(0));
        chk("abort_prdata", 1, 256'(prdata_w[1]), 256'(0));
        model_reset();
        @(posedge pclk); #1;
        psel = 2'b00; penable = 1'b0; preset = 1'b0;
        @(negedge pclk);
        chk("abort_reg2", 1, 256'(regq_w[1][95:64]), 256'(RV1));
        chk("abort_reg_q0", 0, regq_w[0], {8{rv[0]}});
        xfer(1, 32'h08, 1'b1, 32'h0BADCAFE, 4'hF, 1'b0);
        xfer(1, 32'h08, 1'b0, 32'h0, 4'h0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            int          d;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            a = {$urandom_range(0, 10), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            pprot     = 3'($urandom);
            pnse      = 1'($urandom);
            status_in = $urandom;
            xfer(d, a, 1'($urandom), $urandom, 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle();
        end

        idle();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("sb_drained", 0, 256'(sbq0.size()), 256'(0));
        chk("sb_drained", 1, 256'(sbq1.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
